// File: rtl/pq_arbiter.sv
// Round-robin arbiter/sequencer sharing one external max-at-head priority queue
// between NUM_REQ requesters, with a registered response and a drain (flush) mode.
module pq_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ENQ_ENA    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           i_CLK,
  input  logic                           i_RSTn,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [2*NUM_REQ-1:0]           i_req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [DATA_WIDTH-1:0]          o_rsp_data,
  output logic                           o_rsp_err,
  input  logic                           i_flush,
  output logic                           o_flush_busy,
  output logic                           o_pq_wrt,
  output logic                           o_pq_read,
  output logic [DATA_WIDTH-1:0]          o_pq_data,
  input  logic                           i_pq_full,
  input  logic                           i_pq_empty,
  input  logic [DATA_WIDTH-1:0]          i_pq_data,
  output logic [CNT_WIDTH-1:0]           o_err_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;
  localparam logic [1:0] OP_REP = 2'b11;

  typedef enum logic {IDLE, FLUSH} state_t;

  typedef struct packed {
    logic [NUM_REQ-1:0]    vld;
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } rsp_t;

  state_t                            state;
  logic   [PTR_W-1:0]                ptr;
  rsp_t                              rsp;
  logic   [CNT_WIDTH-1:0]            err_cnt;

  logic   [NUM_REQ-1:0][1:0]            op_a;
  logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;

  logic                   gnt_any;
  logic [PTR_W-1:0]       gnt_idx;
  logic [1:0]             gnt_op;
  logic [DATA_WIDTH-1:0]  gnt_data;
  logic                   legal, is_wr, is_rd;

  assign op_a   = i_req_op;
  assign data_a = i_req_data;

  function automatic logic [PTR_W-1:0] wrap(input logic [31:0] v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  // First valid requester at or above ptr, wrapping; no grant while flushing.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    if (state == IDLE && !i_flush) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && i_req_valid[wrap(32'(ptr) + i)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap(32'(ptr) + i);
        end
      end
    end
  end

  assign gnt_op   = op_a[gnt_idx];
  assign gnt_data = data_a[gnt_idx];

  always_comb begin
    legal = 1'b0;
    is_wr = 1'b0;
    is_rd = 1'b0;
    case (gnt_op)
      OP_ENQ: begin
        legal = (ENQ_ENA != 0) && !i_pq_full && (gnt_data != '0);
        is_wr = 1'b1;
      end
      OP_DEQ: begin
        legal = !i_pq_empty;
        is_rd = 1'b1;
      end
      // Replace on an empty queue is legal: the write lands, the read is a no-op.
      OP_REP: begin
        legal = (gnt_data != '0);
        is_wr = 1'b1;
        is_rd = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign o_req_ready  = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign o_pq_wrt     = gnt_any && legal && is_wr;
  assign o_pq_read    = (state == FLUSH) ? !i_pq_empty : (gnt_any && legal && is_rd);
  assign o_pq_data    = gnt_any ? gnt_data : '0;
  assign o_flush_busy = (state == FLUSH);
  assign o_rsp_valid  = rsp.vld;
  assign o_rsp_data   = rsp.data;
  assign o_rsp_err    = rsp.err;
  assign o_err_cnt    = err_cnt;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state   <= IDLE;
      ptr     <= '0;
      rsp     <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE:    if (i_flush)    state <= FLUSH;
        FLUSH:   if (i_pq_empty) state <= IDLE;
        default: state <= IDLE;
      endcase
      rsp.vld <= o_req_ready;
      // Data/err hold between responses; only a grant updates them.
      if (gnt_any) begin
        ptr      <= wrap(32'(gnt_idx) + 32'd1);
        rsp.err  <= !legal;
        rsp.data <= (legal && is_rd) ? i_pq_data : '0;
        if (!legal && err_cnt != '1)
          err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
